alu_decode_pipe: RTL and testbench

Registered, multi-lane successor to the single-lane combinational ALU decoder in the superscalar core's decode stage. Decodes up to LANES instructions per cycle into 5-bit ALU control codes and adds the full RV32M set (mul/mulh/mulhsu/mulhu/div/divu/rem/remu). Flags illegal ALU encodings and holds results in a valid/ready pipeline register. When a decode group holds more M-extension ops than the execute stage has mul/div ports, the block splits the group across beats and keeps program order.

---
 rtl/alu_decode_pipe_if.sv | 33 +++
 rtl/alu_decode_pipe.sv | 162 ++++++++++++++++
 tb/tb_alu_decode_pipe.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_pipe_if.sv
// Decode-group bus between the main decoder (master) and alu_decode_pipe (slave).
// Carries the input group handshake and the output beat handshake.
interface alu_decode_pipe_if #(
  parameter int LANES = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES-1:0]     in_lane_valid;
  logic [LANES-1:0]     in_opb5;
  logic [LANES-1:0]     in_opb0;
  logic [LANES-1:0]     in_funct7b5;
  logic [LANES-1:0]     in_funct7b0;
  logic [3*LANES-1:0]   in_funct3;
  logic [2*LANES-1:0]   in_aluop;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES-1:0]     out_lane_valid;
  logic [5*LANES-1:0]   out_ctrl;
  logic [LANES-1:0]     out_illegal;
  logic [LANES-1:0]     out_muldiv;

  modport master (
    output in_valid, in_lane_valid, in_opb5, in_opb0, in_funct7b5, in_funct7b0,
           in_funct3, in_aluop, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_ctrl, out_illegal, out_muldiv
  );

  modport slave (
    input  in_valid, in_lane_valid, in_opb5, in_opb0, in_funct7b5, in_funct7b0,
           in_funct3, in_aluop, out_ready,
    output in_ready, out_valid, out_lane_valid, out_ctrl, out_illegal, out_muldiv
  );
endinterface

// File: rtl/alu_decode_pipe.sv
// Multi-lane registered ALU control decoder with RV32M support.
// Groups holding more M-ops than MD_PORTS are split across beats in program order.
module alu_decode_pipe #(
  parameter int LANES    = 2,
  parameter int MD_PORTS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_decode_pipe_if.slave bus
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                 state, state_next;

  logic [LANES-1:0][4:0]  dec_ctrl;
  logic [LANES-1:0]       dec_illegal, dec_muldiv;

  logic [LANES-1:0][4:0]  res_ctrl;
  logic [LANES-1:0]       res_valid, res_illegal, res_muldiv;

  logic [LANES-1:0][4:0]  src_ctrl;
  logic [LANES-1:0]       src_valid, src_illegal, src_muldiv;

  logic [LANES-1:0]       take, rest, beat;
  logic [LANES-1:0][4:0]  beat_ctrl;
  logic [2:0]             md_seen;
  logic                   cut;
  logic                   out_free, accept;

  logic                   out_valid_q;
  logic [LANES-1:0]       out_lane_valid_q, out_illegal_q, out_muldiv_q;
  logic [LANES-1:0][4:0]  out_ctrl_q;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = '0;
    dec_muldiv  = '0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.in_aluop[2*i +: 2])
        2'b00: dec_ctrl[i] = 5'b00000;
        2'b01: dec_ctrl[i] = 5'b00001;
        2'b10: begin
          if (bus.in_opb0[i] && bus.in_funct7b0[i]) begin
            dec_ctrl[i]   = {2'b10, bus.in_funct3[3*i +: 3]};
            dec_muldiv[i] = 1'b1;
          end else begin
            case (bus.in_funct3[3*i +: 3])
              3'b000:  dec_ctrl[i] = (bus.in_opb5[i] && bus.in_funct7b5[i]) ? 5'b00001 : 5'b00000;
              3'b001:  dec_ctrl[i] = 5'b01010;
              3'b010:  dec_ctrl[i] = 5'b00101;
              3'b011:  dec_ctrl[i] = 5'b00110;
              3'b100:  dec_ctrl[i] = 5'b00100;
              3'b101:  dec_ctrl[i] = bus.in_funct7b5[i] ? 5'b01011 : 5'b01100;
              3'b110:  dec_ctrl[i] = 5'b00011;
              default: dec_ctrl[i] = 5'b00010;
            endcase
          end
        end
        default: begin
          case (bus.in_funct3[3*i +: 3])
            3'b000:  dec_ctrl[i]    = 5'b01000;
            3'b001:  dec_ctrl[i]    = 5'b01001;
            default: dec_illegal[i] = 1'b1;
          endcase
        end
      endcase
      // Empty lanes must never look like M-ops or raise illegal.
      if (!bus.in_lane_valid[i]) begin
        dec_ctrl[i]    = 5'b00000;
        dec_illegal[i] = 1'b0;
        dec_muldiv[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    src_valid   = (state == SPLIT) ? res_valid   : bus.in_lane_valid;
    src_ctrl    = (state == SPLIT) ? res_ctrl    : dec_ctrl;
    src_illegal = (state == SPLIT) ? res_illegal : dec_illegal;
    src_muldiv  = (state == SPLIT) ? res_muldiv  : dec_muldiv;
  end

  // Once the lane that would exceed the mul/div ports is reached, it and all younger lanes wait.
  always_comb begin
    take    = '0;
    md_seen = 3'd0;
    cut     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (src_valid[i] && !cut) begin
        if (src_muldiv[i] && (md_seen == 3'(MD_PORTS))) begin
          cut = 1'b1;
        end else begin
          take[i] = 1'b1;
          if (src_muldiv[i]) md_seen = md_seen + 3'd1;
        end
      end
    end
  end

  assign rest     = src_valid & ~take;
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign beat     = ((state == SPLIT) || accept) ? take : '0;

  always_comb begin
    beat_ctrl = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_ctrl[i] = beat[i] ? src_ctrl[i] : 5'b00000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (|rest)) state_next = SPLIT;
      SPLIT:   if (out_free && !(|rest)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_lane_valid_q <= '0;
      out_ctrl_q       <= '0;
      out_illegal_q    <= '0;
      out_muldiv_q     <= '0;
      res_valid        <= '0;
      res_ctrl         <= '0;
      res_illegal      <= '0;
      res_muldiv       <= '0;
    end else begin
      if (out_free) begin
        out_valid_q      <= |beat;
        out_lane_valid_q <= beat;
        out_ctrl_q       <= beat_ctrl;
        out_illegal_q    <= src_illegal & beat;
        out_muldiv_q     <= src_muldiv & beat;
      end
      if (accept || ((state == SPLIT) && out_free)) begin
        res_valid   <= rest;
        res_ctrl    <= src_ctrl;
        res_illegal <= src_illegal;
        res_muldiv  <= src_muldiv;
      end
    end
  end

  assign bus.in_ready       = (state == IDLE) && out_free;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_lane_valid = out_lane_valid_q;
  assign bus.out_ctrl       = out_ctrl_q;
  assign bus.out_illegal    = out_illegal_q;
  assign bus.out_muldiv     = out_muldiv_q;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Scoreboard bench for alu_decode_pipe (LANES=4, MD_PORTS=2): directed groups with
// hand-decoded lane codes; a monitor pops expected beats whenever a beat is taken.
module tb_alu_decode_pipe;

  localparam int LANES    = 4;
  localparam int MD_PORTS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_decode_pipe_if #(.LANES(LANES)) bus ();

  alu_decode_pipe #(.LANES(LANES), .MD_PORTS(MD_PORTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  lv, opb5, opb0, f7b5, f7b0;
    logic [11:0] f3;
    logic [7:0]  aluop;
    logic [19:0] ectrl;
    logic [3:0]  eill, emd;
  } grp_t;

  typedef struct {
    logic [3:0]  lv;
    logic [19:0] ctrl;
    logic [3:0]  ill, md;
  } beat_t;

  beat_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic grp_t emptyGroup();
    grp_t g;
    g.lv = '0; g.opb5 = '0; g.opb0 = '0; g.f7b5 = '0; g.f7b0 = '0;
    g.f3 = '0; g.aluop = '0; g.ectrl = '0; g.eill = '0; g.emd = '0;
    return g;
  endfunction

  function automatic grp_t putLane(input grp_t g, input int i, input logic v,
                                   input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic opb5, input logic opb0,
                                   input logic f7b5, input logic f7b0,
                                   input logic [4:0] ectrl, input logic eill, input logic emd);
    grp_t r;
    r = g;
    r.lv[i] = v; r.opb5[i] = opb5; r.opb0[i] = opb0; r.f7b5[i] = f7b5; r.f7b0[i] = f7b0;
    r.aluop[2*i +: 2] = aluop;
    r.f3[3*i +: 3]    = f3;
    r.ectrl[5*i +: 5] = ectrl;
    r.eill[i] = eill;
    r.emd[i]  = emd;
    return r;
  endfunction

  // Build beats lane by lane; a new beat opens when an M-op finds the ports already full.
  task automatic pushExpected(input grp_t g);
    beat_t b;
    int    md;
    b.lv = '0; b.ctrl = '0; b.ill = '0; b.md = '0;
    md = 0;
    for (int i = 0; i < LANES; i++) begin
      if (g.lv[i]) begin
        if (g.emd[i] && md == MD_PORTS) begin
          sb.push_back(b);
          b.lv = '0; b.ctrl = '0; b.ill = '0; b.md = '0;
          md = 0;
        end
        b.lv[i] = 1'b1;
        b.ctrl[5*i +: 5] = g.ectrl[5*i +: 5];
        b.ill[i] = g.eill[i];
        b.md[i]  = g.emd[i];
        if (g.emd[i]) md++;
      end
    end
    if (b.lv != 4'b0000) sb.push_back(b);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input grp_t g);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    pushExpected(g);
    bus.in_valid      = 1'b1;
    bus.in_lane_valid = g.lv;
    bus.in_opb5       = g.opb5;
    bus.in_opb0       = g.opb0;
    bus.in_funct7b5   = g.f7b5;
    bus.in_funct7b0   = g.f7b0;
    bus.in_funct3     = g.f3;
    bus.in_aluop      = g.aluop;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic checkOutput();
    beat_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_beat: got lv=%b ctrl=%b, expected no beat",
               bus.out_lane_valid, bus.out_ctrl);
    end else begin
      e = sb.pop_front();
      if (bus.out_lane_valid !== e.lv || bus.out_ctrl !== e.ctrl ||
          bus.out_illegal !== e.ill || bus.out_muldiv !== e.md) begin
        miscompares++;
        $display("[TB] FAIL beat: got lv=%b ctrl=%b ill=%b md=%b, expected lv=%b ctrl=%b ill=%b md=%b",
                 bus.out_lane_valid, bus.out_ctrl, bus.out_illegal, bus.out_muldiv,
                 e.lv, e.ctrl, e.ill, e.md);
      end
    end
    vectors++;
    if ($countones(bus.out_muldiv) > MD_PORTS) begin
      miscompares++;
      $display("[TB] FAIL md_ports: got %0d muldiv lanes, expected at most %0d",
               $countones(bus.out_muldiv), MD_PORTS);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    checkValue("drain_pending_beats", sb.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) checkOutput();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, expected earlier");
    $fatal(1, "[TB] watchdog");
  end

  grp_t v1, v2, v3, v4, v5, v6, v7, v8, v9, v10;

  initial begin
    bus.in_valid = 1'b0; bus.in_lane_valid = '0; bus.in_opb5 = '0; bus.in_opb0 = '0;
    bus.in_funct7b5 = '0; bus.in_funct7b0 = '0; bus.in_funct3 = '0; bus.in_aluop = '0;
    bus.out_ready = 1'b1;

    // add, sra, sub, and
    v1 = emptyGroup();
    v1 = putLane(v1, 0, 1, 2'b10, 3'b000, 1, 1, 0, 0, 5'b00000, 0, 0);
    v1 = putLane(v1, 1, 1, 2'b10, 3'b101, 1, 1, 1, 0, 5'b01011, 0, 0);
    v1 = putLane(v1, 2, 1, 2'b10, 3'b000, 1, 1, 1, 0, 5'b00001, 0, 0);
    v1 = putLane(v1, 3, 1, 2'b10, 3'b111, 1, 1, 0, 0, 5'b00010, 0, 0);
    // mul, divu, rem, addi with imm[10] set
    v2 = emptyGroup();
    v2 = putLane(v2, 0, 1, 2'b10, 3'b000, 1, 1, 0, 1, 5'b10000, 0, 1);
    v2 = putLane(v2, 1, 1, 2'b10, 3'b101, 1, 1, 0, 1, 5'b10101, 0, 1);
    v2 = putLane(v2, 2, 1, 2'b10, 3'b110, 1, 1, 0, 1, 5'b10110, 0, 1);
    v2 = putLane(v2, 3, 1, 2'b10, 3'b000, 0, 1, 1, 0, 5'b00000, 0, 0);
    // lui, illegal ALUOp 11, auipc, empty lane carrying mul fields
    v3 = emptyGroup();
    v3 = putLane(v3, 0, 1, 2'b11, 3'b001, 0, 1, 0, 0, 5'b01001, 0, 0);
    v3 = putLane(v3, 1, 1, 2'b11, 3'b010, 0, 1, 0, 0, 5'b00000, 1, 0);
    v3 = putLane(v3, 2, 1, 2'b11, 3'b000, 0, 1, 0, 0, 5'b01000, 0, 0);
    v3 = putLane(v3, 3, 0, 2'b10, 3'b000, 1, 1, 0, 1, 5'b00000, 0, 0);
    // no valid lanes at all
    v4 = emptyGroup();
    for (int i = 0; i < LANES; i++) v4 = putLane(v4, i, 0, 2'b10, 3'b000, 1, 1, 0, 1, 5'b00000, 0, 0);
    // mulh, hole with mul fields, div, remu
    v5 = emptyGroup();
    v5 = putLane(v5, 0, 1, 2'b10, 3'b001, 1, 1, 0, 1, 5'b10001, 0, 1);
    v5 = putLane(v5, 1, 0, 2'b10, 3'b000, 1, 1, 0, 1, 5'b00000, 0, 0);
    v5 = putLane(v5, 2, 1, 2'b10, 3'b100, 1, 1, 0, 1, 5'b10100, 0, 1);
    v5 = putLane(v5, 3, 1, 2'b10, 3'b111, 1, 1, 0, 1, 5'b10111, 0, 1);
    // sll with opb0=0 and f7b0=1, slt, sltu, srl
    v6 = emptyGroup();
    v6 = putLane(v6, 0, 1, 2'b10, 3'b001, 1, 0, 0, 1, 5'b01010, 0, 0);
    v6 = putLane(v6, 1, 1, 2'b10, 3'b010, 1, 1, 0, 0, 5'b00101, 0, 0);
    v6 = putLane(v6, 2, 1, 2'b10, 3'b011, 1, 1, 0, 0, 5'b00110, 0, 0);
    v6 = putLane(v6, 3, 1, 2'b10, 3'b101, 1, 1, 0, 0, 5'b01100, 0, 0);
    // ALUOp 00, ALUOp 01 with M bits set, or, mulhsu
    v7 = emptyGroup();
    v7 = putLane(v7, 0, 1, 2'b00, 3'b111, 1, 1, 1, 1, 5'b00000, 0, 0);
    v7 = putLane(v7, 1, 1, 2'b01, 3'b101, 1, 1, 0, 1, 5'b00001, 0, 0);
    v7 = putLane(v7, 2, 1, 2'b10, 3'b110, 1, 1, 0, 0, 5'b00011, 0, 0);
    v7 = putLane(v7, 3, 1, 2'b10, 3'b010, 1, 1, 0, 1, 5'b10010, 0, 1);
    // four M-ops: mul, mulh, div, rem
    v8 = emptyGroup();
    v8 = putLane(v8, 0, 1, 2'b10, 3'b000, 1, 1, 0, 1, 5'b10000, 0, 1);
    v8 = putLane(v8, 1, 1, 2'b10, 3'b001, 1, 1, 0, 1, 5'b10001, 0, 1);
    v8 = putLane(v8, 2, 1, 2'b10, 3'b100, 1, 1, 0, 1, 5'b10100, 0, 1);
    v8 = putLane(v8, 3, 1, 2'b10, 3'b110, 1, 1, 0, 1, 5'b10110, 0, 1);
    // mul, mul, xor, mulhu: the xor rides in the first beat
    v9 = emptyGroup();
    v9 = putLane(v9, 0, 1, 2'b10, 3'b000, 1, 1, 0, 1, 5'b10000, 0, 1);
    v9 = putLane(v9, 1, 1, 2'b10, 3'b000, 1, 1, 0, 1, 5'b10000, 0, 1);
    v9 = putLane(v9, 2, 1, 2'b10, 3'b100, 1, 1, 0, 0, 5'b00100, 0, 0);
    v9 = putLane(v9, 3, 1, 2'b10, 3'b011, 1, 1, 0, 1, 5'b10011, 0, 1);
    // single srai lane
    v10 = emptyGroup();
    v10 = putLane(v10, 0, 1, 2'b10, 3'b101, 0, 1, 1, 0, 5'b01011, 0, 0);

    #12;
    checkValue("reset_out_valid", bus.out_valid, 0);
    checkValue("reset_lane_valid", bus.out_lane_valid, 0);
    checkValue("reset_ctrl", bus.out_ctrl, 0);
    checkValue("reset_illegal", bus.out_illegal, 0);
    checkValue("reset_muldiv", bus.out_muldiv, 0);
    checkValue("reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(v1);
    @(negedge clk);
    checkValue("in_ready_no_split", bus.in_ready, 1);
    checkValue("out_valid_latency", bus.out_valid, 1);

    applyStimulus(v2);
    @(negedge clk);
    checkValue("in_ready_split", bus.in_ready, 0);

    applyStimulus(v3);
    applyStimulus(v4);
    applyStimulus(v5);
    applyStimulus(v6);
    applyStimulus(v7);
    applyStimulus(v9);
    applyStimulus(v10);
    drain();

    // Backpressure: hold a beat, queue a second group behind it, then release.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(v6);
    fork
      applyStimulus(v1);
      begin
        repeat (3) begin
          @(negedge clk);
          checkValue("stall_out_valid", bus.out_valid, 1);
          checkValue("stall_ctrl", bus.out_ctrl, {5'b01100, 5'b00110, 5'b00101, 5'b01010});
          checkValue("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkValue("release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        checkValue("no_bubble_out_valid", bus.out_valid, 1);
        checkValue("no_bubble_ctrl", bus.out_ctrl, {5'b00010, 5'b00001, 5'b01011, 5'b00000});
      end
    join
    drain();

    // Reset while a split group still has a residual beat pending.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(v8);
    @(negedge clk);
    checkValue("split_in_ready", bus.in_ready, 0);
    checkValue("split_first_lanes", bus.out_lane_valid, 4'b0011);
    #1 rst_n = 1'b0;
    #1;
    checkValue("midreset_out_valid", bus.out_valid, 0);
    checkValue("midreset_lane_valid", bus.out_lane_valid, 0);
    checkValue("midreset_ctrl", bus.out_ctrl, 0);
    checkValue("midreset_illegal", bus.out_illegal, 0);
    checkValue("midreset_muldiv", bus.out_muldiv, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkValue("no_residual_after_reset", bus.out_valid, 0);
    end

    applyStimulus(v10);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
